// File: rtl/dram_arb.sv
// dram_arb: arbiter/sequencer for the single data-RAM port shared by the
// UART host loader (port H) and the hxd32 CPU data port (port C).
//
// One access is granted per cycle (combinational grant). The granted command
// is registered onto the ram_* outputs. Read data returns on the granting
// port two cycles after the grant (1 cycle command register + 1 cycle RAM).
// Round-robin between H and C; the host may lock the port, and a saturating
// wait counter force-grants C after MAX_WAIT cycles of starvation.
//
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   h_req_i/h_lock_i/h_we_i      host request, lock, write select
//   h_addr_i/h_wr_data_i         host byte address, write data
//   h_wr_byte_en_i               host write byte enables
//   h_gnt_o                      host request accepted this cycle
//   h_rd_data_o/h_rd_vld_o       host read data (0 unless valid), valid strobe
//   c_*                          CPU equivalents (no lock)
//   ram_en_o/ram_we_o            RAM command valid, byte write enables (0=read)
//   ram_addr_o/ram_wr_data_o     RAM address, write data
//   ram_rd_data_i                RAM read data, 1 cycle after a read command
module dram_arb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            h_req_i,
    input  logic            h_lock_i,
    input  logic            h_we_i,
    input  logic [XLEN-1:0] h_addr_i,
    input  logic [XLEN-1:0] h_wr_data_i,
    input  logic [3:0]      h_wr_byte_en_i,
    output logic            h_gnt_o,
    output logic [XLEN-1:0] h_rd_data_o,
    output logic            h_rd_vld_o,
    input  logic            c_req_i,
    input  logic            c_we_i,
    input  logic [XLEN-1:0] c_addr_i,
    input  logic [XLEN-1:0] c_wr_data_i,
    input  logic [3:0]      c_wr_byte_en_i,
    output logic            c_gnt_o,
    output logic [XLEN-1:0] c_rd_data_o,
    output logic            c_rd_vld_o,
    output logic            ram_en_o,
    output logic [3:0]      ram_we_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic [XLEN-1:0] ram_wr_data_o,
    input  logic [XLEN-1:0] ram_rd_data_i
);

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    typedef enum logic {
        LAST_C = 1'b0,
        LAST_H = 1'b1
    } last_t;

    last_t      last_q, last_d;
    logic [7:0] wait_q, wait_d;
    logic       h_gnt, c_gnt;

    // Read-return tag pipeline: {vld, src_is_h} delayed two cycles.
    logic       tag1_vld, tag1_h;
    logic       tag2_vld, tag2_h;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= LAST_C;
            wait_q <= '0;
        end else begin
            last_q <= last_d;
            wait_q <= wait_d;
        end
    end

    // Grant, last-grant pointer and wait counter next state
    always_comb begin
        h_gnt  = 1'b0;
        c_gnt  = 1'b0;
        last_d = last_q;
        wait_d = wait_q;

        if ((wait_q == WAIT_MAX) && c_req_i) begin
            c_gnt = 1'b1;
        end else if (h_lock_i && (last_q == LAST_H)) begin
            // Locked: C is shut out even when H is idle this cycle.
            h_gnt = h_req_i;
        end else if (h_req_i && c_req_i) begin
            if (last_q == LAST_H) c_gnt = 1'b1;
            else                  h_gnt = 1'b1;
        end else begin
            h_gnt = h_req_i;
            c_gnt = c_req_i;
        end

        if (h_gnt)      last_d = LAST_H;
        else if (c_gnt) last_d = LAST_C;

        // A pending C request at WAIT_MAX is always granted, so the
        // counter never needs to advance past it.
        if (!c_req_i || c_gnt)      wait_d = '0;
        else if (wait_q != WAIT_MAX) wait_d = wait_q + 8'd1;
    end

    assign h_gnt_o = h_gnt;
    assign c_gnt_o = c_gnt;

    // Command register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ram_en_o      <= 1'b0;
            ram_we_o      <= '0;
            ram_addr_o    <= '0;
            ram_wr_data_o <= '0;
        end else if (h_gnt) begin
            ram_en_o      <= 1'b1;
            ram_we_o      <= h_we_i ? h_wr_byte_en_i : 4'b0000;
            ram_addr_o    <= h_addr_i;
            ram_wr_data_o <= h_wr_data_i;
        end else if (c_gnt) begin
            ram_en_o      <= 1'b1;
            ram_we_o      <= c_we_i ? c_wr_byte_en_i : 4'b0000;
            ram_addr_o    <= c_addr_i;
            ram_wr_data_o <= c_wr_data_i;
        end else begin
            ram_en_o <= 1'b0;
            ram_we_o <= '0;
        end
    end

    // Read tag pipeline
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tag1_vld <= 1'b0;
            tag1_h   <= 1'b0;
            tag2_vld <= 1'b0;
            tag2_h   <= 1'b0;
        end else begin
            tag1_vld <= (h_gnt && !h_we_i) || (c_gnt && !c_we_i);
            tag1_h   <= h_gnt;
            tag2_vld <= tag1_vld;
            tag2_h   <= tag1_h;
        end
    end

    assign h_rd_vld_o  = tag2_vld && tag2_h;
    assign c_rd_vld_o  = tag2_vld && !tag2_h;
    assign h_rd_data_o = h_rd_vld_o ? ram_rd_data_i : '0;
    assign c_rd_data_o = c_rd_vld_o ? ram_rd_data_i : '0;

endmodule

// File: tb/tb_dram_arb.sv
// Testbench for dram_arb: directed per-cycle vectors with hand-computed
// grants; expected RAM commands and read returns go into scoreboard queues
// and are checked by an independent monitor on the falling clock edge.
module tb_dram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        h_req, h_lock, h_we, c_req, c_we;
    logic [31:0] h_addr, h_wr_data, c_addr, c_wr_data;
    logic [3:0]  h_be, c_be;
    logic        h_gnt, c_gnt, h_rd_vld, c_rd_vld;
    logic [31:0] h_rd_data, c_rd_data;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr, ram_wr_data, ram_rd_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        int          due;
        bit          is_h;
        logic [31:0] data;
    } rd_t;

    cmd_t cmd_q[$];
    rd_t  rd_q[$];

    dram_arb #(.XLEN(32), .MAX_WAIT(8)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .h_req_i        (h_req),
        .h_lock_i       (h_lock),
        .h_we_i         (h_we),
        .h_addr_i       (h_addr),
        .h_wr_data_i    (h_wr_data),
        .h_wr_byte_en_i (h_be),
        .h_gnt_o        (h_gnt),
        .h_rd_data_o    (h_rd_data),
        .h_rd_vld_o     (h_rd_vld),
        .c_req_i        (c_req),
        .c_we_i         (c_we),
        .c_addr_i       (c_addr),
        .c_wr_data_i    (c_wr_data),
        .c_wr_byte_en_i (c_be),
        .c_gnt_o        (c_gnt),
        .c_rd_data_o    (c_rd_data),
        .c_rd_vld_o     (c_rd_vld),
        .ram_en_o       (ram_en),
        .ram_we_o       (ram_we),
        .ram_addr_o     (ram_addr),
        .ram_wr_data_o  (ram_wr_data),
        .ram_rd_data_i  (ram_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM contents are a fixed function of the address.
    function automatic logic [31:0] ram_f(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // Synchronous RAM model, 1-cycle read latency; junk when not reading.
    always @(posedge clk) begin
        if (ram_en && ram_we == 4'b0000) ram_rd_data <= ram_f(ram_addr);
        else                             ram_rd_data <= 32'hFFFF_FFFF;
    end

    function automatic void chk(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a command or read.
    always @(negedge clk) begin
        cmd_t c;
        rd_t  r;
        if (ram_en) begin
            if (cmd_q.size() == 0) begin
                chk(1'b0, "cmd_spurious", ram_addr, 32'h0);
            end else begin
                c = cmd_q.pop_front();
                chk(c.due == cyc, "cmd_cycle", cyc, c.due);
                chk(ram_addr == c.addr, "cmd_addr", ram_addr, c.addr);
                chk(ram_we == c.we, "cmd_we", {28'h0, ram_we}, {28'h0, c.we});
                if (c.we != 4'b0000)
                    chk(ram_wr_data == c.data, "cmd_wdata", ram_wr_data, c.data);
            end
        end else if (cmd_q.size() > 0 && cmd_q[0].due <= cyc) begin
            c = cmd_q.pop_front();
            chk(1'b0, "cmd_missing", 32'h0, c.addr);
        end

        chk(!(h_rd_vld && c_rd_vld), "rd_vld_both", {31'h0, c_rd_vld}, 32'h0);
        if (h_rd_vld || c_rd_vld) begin
            if (rd_q.size() == 0) begin
                chk(1'b0, "rd_spurious", {31'h0, h_rd_vld}, 32'h0);
            end else begin
                r = rd_q.pop_front();
                chk(r.due == cyc, "rd_cycle", cyc, r.due);
                chk(h_rd_vld == r.is_h, "rd_port_h", {31'h0, h_rd_vld}, {31'h0, r.is_h});
                chk((r.is_h ? h_rd_data : c_rd_data) == r.data, "rd_data",
                    r.is_h ? h_rd_data : c_rd_data, r.data);
            end
        end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            r = rd_q.pop_front();
            chk(1'b0, "rd_missing", 32'h0, r.data);
        end

        if (!h_rd_vld) chk(h_rd_data == 32'h0, "h_rd_gate", h_rd_data, 32'h0);
        if (!c_rd_vld) chk(c_rd_data == 32'h0, "c_rd_gate", c_rd_data, 32'h0);
    end

    task automatic set_h(input logic req, lock, we, input logic [31:0] a, d,
                         input logic [3:0] be);
        h_req = req; h_lock = lock; h_we = we; h_addr = a; h_wr_data = d; h_be = be;
    endtask

    task automatic set_c(input logic req, we, input logic [31:0] a, d,
                         input logic [3:0] be);
        c_req = req; c_we = we; c_addr = a; c_wr_data = d; c_be = be;
    endtask

    // One cycle: check hand-computed grants, queue the expected response.
    task automatic tick(input bit eh, input bit ec, input bit push);
        cmd_t c;
        rd_t  r;
        @(negedge clk);
        chk(h_gnt == eh, "h_gnt", {31'h0, h_gnt}, {31'h0, eh});
        chk(c_gnt == ec, "c_gnt", {31'h0, c_gnt}, {31'h0, ec});
        if (push && (eh || ec)) begin
            c.due  = cyc + 1;
            c.addr = eh ? h_addr : c_addr;
            c.we   = eh ? (h_we ? h_be : 4'b0000) : (c_we ? c_be : 4'b0000);
            c.data = eh ? h_wr_data : c_wr_data;
            cmd_q.push_back(c);
            if (c.we == 4'b0000) begin
                r.due  = cyc + 2;
                r.is_h = eh;
                r.data = ram_f(c.addr);
                rd_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_h(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1);
    endtask

    // Two reset cycles with all outputs checked at zero.
    task automatic do_reset();
        rst_n = 1'b0;
        set_h(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk(h_gnt == 1'b0, "rst_h_gnt", {31'h0, h_gnt}, 32'h0);
            chk(c_gnt == 1'b0, "rst_c_gnt", {31'h0, c_gnt}, 32'h0);
            chk(h_rd_vld == 1'b0, "rst_h_vld", {31'h0, h_rd_vld}, 32'h0);
            chk(c_rd_vld == 1'b0, "rst_c_vld", {31'h0, c_rd_vld}, 32'h0);
            chk(ram_en == 1'b0, "rst_ram_en", {31'h0, ram_en}, 32'h0);
            chk(ram_we == 4'h0, "rst_ram_we", {28'h0, ram_we}, 32'h0);
            chk(ram_addr == 32'h0, "rst_ram_addr", ram_addr, 32'h0);
            chk(ram_wr_data == 32'h0, "rst_ram_wdata", ram_wr_data, 32'h0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_h(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;

        // Single host read of 0x10, returns 0xDEADBEEF two cycles later.
        do_reset();
        set_h(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        tick(1'b1, 1'b0, 1'b1);
        idle(3);

        // Both requesting from reset: H,C,H,C.
        do_reset();
        set_h(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        set_c(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        tick(1'b1, 1'b0, 1'b1);
        set_h(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 4'h0);
        tick(1'b0, 1'b1, 1'b1);
        set_c(1'b1, 1'b0, 32'h204, 32'h0, 4'h0);
        tick(1'b1, 1'b0, 1'b1);
        set_h(1'b1, 1'b0, 1'b0, 32'h108, 32'h0, 4'h0);
        tick(1'b0, 1'b1, 1'b1);
        idle(2);

        // CPU partial write: no read return expected.
        set_c(1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011);
        tick(1'b0, 1'b1, 1'b1);
        idle(2);

        // Host lock with CPU starving: C forced on its 9th request cycle.
        set_c(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            set_h(1'b1, 1'b1, 1'b0, 32'h300 + 32'(4 * k), 32'h0, 4'h0);
            tick(1'b1, 1'b0, 1'b1);
        end
        set_h(1'b1, 1'b1, 1'b0, 32'h320, 32'h0, 4'h0);
        tick(1'b0, 1'b1, 1'b1);
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick(1'b1, 1'b0, 1'b1);

        // Lock held with H idle: C blocked until the lock drops.
        set_h(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_c(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b1);
        set_h(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick(1'b0, 1'b1, 1'b1);
        idle(3);

        // Reset the cycle after an H read grant: that read must never return.
        set_h(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 4'h0);
        tick(1'b1, 1'b0, 1'b0);
        do_reset();
        set_h(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 4'h0);
        set_c(1'b1, 1'b0, 32'h800, 32'h0, 4'h0);
        tick(1'b1, 1'b0, 1'b1);
        set_h(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick(1'b0, 1'b1, 1'b1);
        idle(4);

        chk(cmd_q.size() == 0, "cmd_q_empty", cmd_q.size(), 32'h0);
        chk(rd_q.size() == 0, "rd_q_empty", rd_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_arb.md
Name: dram_arb

Overview:
Arbiter and sequencer for the single data-RAM port, shared by two requesters: the UART host loader (port H) and the hxd32 CPU data port (port C).
It accepts one access per cycle and issues a registered command to a synchronous RAM with 1-cycle read latency. It returns read data to the granted requester with a fixed latency.
Arbitration is round-robin. The host can also hold the port exclusively with a lock, and a wait counter bounds how long the CPU can starve.

Parameters:
XLEN, 32, data and address width
MAX_WAIT, 8, cycles port C may wait with req high before it is force-granted (1..255)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
h_req_i  in  1  host access request; held with cmd fields until h_gnt_o
h_lock_i  in  1  host lock; while high and H was last granted, only H is granted
h_we_i  in  1  host write (1) / read (0)
h_addr_i  in  XLEN  host byte address
h_wr_data_i  in  XLEN  host write data
h_wr_byte_en_i  in  4  host byte enables (write only)
h_gnt_o  out  1  host request accepted this cycle
h_rd_data_o  out  XLEN  host read data
h_rd_vld_o  out  1  host read data valid
c_req_i, c_we_i, c_addr_i, c_wr_data_i, c_wr_byte_en_i  in  1/1/XLEN/XLEN/4  CPU equivalents
c_gnt_o, c_rd_data_o, c_rd_vld_o  out  1/XLEN/1  CPU equivalents
ram_en_o  out  1  RAM command valid
ram_we_o  out  4  RAM byte write enables; 0 = read
ram_addr_o  out  XLEN  RAM address
ram_wr_data_o  out  XLEN  RAM write data
ram_rd_data_i  in  XLEN  RAM read data, valid 1 cycle after a read command

Behaviour:
- Reset values: all outputs 0; last-grant pointer = C, so H wins the first tie; wait counter = 0; read-tag pipeline cleared.
- Grant (combinational, cycle N):
  - At most one of h_gnt_o/c_gnt_o is high.
  - Only one requester: it is granted.
  - Both requesting: the one not granted last wins.
  - Overrides, highest priority first:
    - wait_cnt == MAX_WAIT and c_req_i: C is granted.
    - Else h_lock_i and last = H: H is granted; C is not granted even if H is idle that cycle.
- Last-grant pointer updates on every grant.
- Command register: at the clock edge ending cycle N, the granted requester's fields load into the ram_* outputs.
  - ram_en_o = 1.
  - ram_we_o = byte_en if we, else 4'b0000.
  - With no grant, ram_en_o = 0 and ram_we_o = 0; addr/data hold their previous value.
- Read return: for a read granted in cycle N, RAM sees the command in N+1 and data arrives in N+2.
  - {src, vld} tag is delayed 2 cycles; in N+2 the matching x_rd_vld_o = 1 for exactly one cycle.
  - x_rd_data_o = ram_rd_data_i, gated to 0 when not valid.
  - Writes produce no rd_vld.
- Throughput: back-to-back grants every cycle; interleaved H/C reads return in grant order.
- Wait counter (saturating at MAX_WAIT):
  - Increments each cycle c_req_i && !c_gnt_o.
  - Clears on c_gnt_o or when !c_req_i.
- Requester contract: cmd fields stable from req high until gnt; req may drop in the gnt cycle or stay high for a new access.
- Reset asserted mid-operation: in-flight tags are discarded, so no rd_vld_o appears after reset; ram_en_o drops immediately (asynchronous).
- Lock: h_lock_i sampled only for arbitration; lock release takes effect the same cycle.

Test Plan:
- Reset, then H read addr 0x10 alone: h_gnt_o in cycle 0; ram_en_o=1, ram_we_o=0, ram_addr_o=0x10 in cycle 1; RAM returns 0xDEADBEEF; h_rd_vld_o=1 and h_rd_data_o=0xDEADBEEF in cycle 2 only; c_rd_vld_o stays 0.
- H and C both request continuously from reset: grants alternate H,C,H,C; ram_addr_o follows with 1-cycle lag; each read returns on the correct port 2 cycles after its grant.
- C write addr 0x20, data 0x12345678, byte_en 4'b0011: ram_we_o=4'b0011, ram_wr_data_o=0x12345678 one cycle after c_gnt_o; no rd_vld on either port.
- H locked (h_lock_i=1, streaming reads) while C requests with MAX_WAIT=8: C waits, then C is granted exactly on its 9th request cycle; the counter clears and H resumes the next cycle.
- Lock held with h_req_i=0 and c_req_i=1: no grant while wait_cnt<MAX_WAIT; after h_lock_i drops, C is granted the same cycle.
- Reset pulse one cycle after an H read grant: no h_rd_vld_o afterwards; all outputs 0 during reset; first post-reset tie goes to H.
